// File: rtl/console_link_pkg.sv
// Shared symbols, sizes and FSM encoding for the console 2-bit serial memory link.
package console_link_pkg;

    localparam int CHUNKS  = 8;
    localparam int CHUNK_W = 2;
    localparam int WORD_W  = 16;

    localparam logic [CHUNK_W-1:0] SYM_IDLE  = 2'b00;
    localparam logic [CHUNK_W-1:0] SYM_READ  = 2'b01;
    localparam logic [CHUNK_W-1:0] SYM_WRITE = 2'b10;
    localparam logic [CHUNK_W-1:0] SYM_ERR   = 2'b11;
    localparam logic [CHUNK_W-1:0] SYM_START = 2'b01;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, WAIT, RSTART, RDATA} state_t;

endpackage

// File: rtl/console_mem_ram.sv
// 2^AW x 16 word RAM: one write port, synchronous read, read-before-write on a shared address.
module console_mem_ram
    import console_link_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [0:(2**AW)-1];

    // rdata only moves on a read, so it holds the captured word for the whole response
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/console_mem_responder.sv
// Host-side responder for the console serial memory link; serves 16-bit words from local RAM.
// Define CONSOLE_MEM_WRITE_EN to let console write frames update the RAM.
module console_mem_responder
    import console_link_pkg::*;
#(
    parameter int MEM_AW     = 10,
    parameter int RESP_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [1:0]        tx_in,
    output logic [1:0]        rx_out,
    input  logic              load_we,
    input  logic [MEM_AW-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    output logic              busy,
    output logic              err_overrun
);

    localparam int DLY_W = $clog2(RESP_DELAY + 1);
    localparam logic [2:0] LAST = 3'(CHUNKS - 1);

    state_t              state;
    logic [2:0]          cnt;
    logic [DLY_W-1:0]    dly;
    logic                is_wr;
    logic [WORD_W-1:0]   addr_sr, data_sr, resp_sr;
    logic [WORD_W-1:0]   addr_nxt, wdata_nxt, ram_rdata;
    logic                cons_we, rd_issue, ram_we;
    logic [MEM_AW-1:0]   ram_waddr;
    logic [WORD_W-1:0]   ram_wdata;
    logic                unused_bits;

    assign addr_nxt  = {tx_in, addr_sr[WORD_W-1:CHUNK_W]};
    assign wdata_nxt = {tx_in, data_sr[WORD_W-1:CHUNK_W]};
    assign busy      = (state != IDLE);
    assign rd_issue  = ena && (state == WAIT) && (dly == '0);

`ifdef CONSOLE_MEM_WRITE_EN
    assign cons_we = ena && (state == WDATA) && (cnt == LAST);
`else
    assign cons_we = 1'b0;
`endif

    // Host preload wins the write port outright; a colliding console write is dropped
    assign ram_we    = load_we | cons_we;
    assign ram_waddr = load_we ? load_addr : addr_sr[MEM_AW-1:0];
    assign ram_wdata = load_we ? load_data : wdata_nxt;

    assign unused_bits = ^{addr_sr >> MEM_AW, data_sr[CHUNK_W-1:0]};

    console_mem_ram #(.AW(MEM_AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_issue),
        .raddr (addr_sr[MEM_AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dly         <= '0;
            is_wr       <= 1'b0;
            addr_sr     <= '0;
            data_sr     <= '0;
            resp_sr     <= '0;
            rx_out      <= SYM_IDLE;
            err_overrun <= 1'b0;
        end else if (!ena) begin
            state       <= IDLE;
            cnt         <= '0;
            dly         <= '0;
            rx_out      <= SYM_IDLE;
            err_overrun <= 1'b0;
        end else begin
            // Anything but idle while we own the line is a dropped symbol
            err_overrun <= (state inside {WAIT, RSTART, RDATA}) ? (tx_in != SYM_IDLE)
                                                               : (state == IDLE && tx_in == SYM_ERR);
            case (state)
                IDLE: begin
                    rx_out <= SYM_IDLE;
                    cnt    <= '0;
                    if (tx_in == SYM_READ || tx_in == SYM_WRITE) begin
                        state <= ADDR;
                        is_wr <= (tx_in == SYM_WRITE);
                    end
                end
                ADDR: begin
                    addr_sr <= addr_nxt;
                    cnt     <= cnt + 3'd1;
                    dly     <= '0;
                    if (cnt == LAST) state <= is_wr ? WDATA : WAIT;
                end
                WDATA: begin
                    data_sr <= wdata_nxt;
                    cnt     <= cnt + 3'd1;
                    if (cnt == LAST) state <= IDLE;
                end
                WAIT: begin
                    dly <= dly + DLY_W'(1);
                    if (dly == DLY_W'(RESP_DELAY - 1)) state <= RSTART;
                end
                RSTART: begin
                    rx_out  <= SYM_START;
                    resp_sr <= ram_rdata;
                    cnt     <= '0;
                    state   <= RDATA;
                end
                RDATA: begin
                    rx_out  <= resp_sr[CHUNK_W-1:0];
                    resp_sr <= resp_sr >> CHUNK_W;
                    cnt     <= cnt + 3'd1;
                    if (cnt == LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_console_mem_responder.sv
// Self-checking bench for console_mem_responder: vector table, corner sequences, random frames vs a word-level memory model.
module tb_console_mem_responder;

    localparam int AW = 10;
    localparam int R  = 2;
`ifdef CONSOLE_MEM_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b1, ena = 1'b0, load_we = 1'b0;
    logic [1:0]    tx_in = 2'b00, rx_out;
    logic [AW-1:0] load_addr = '0;
    logic [15:0]   load_data = '0;
    logic          busy, err_overrun;

    int n_chk = 0, n_fail = 0;
    logic [15:0] mdl [0:(1<<AW)-1];

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [0:6];

    always #5 clk = ~clk;

    console_mem_responder #(.MEM_AW(AW), .RESP_DELAY(R)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tx_in(tx_in), .rx_out(rx_out),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .busy(busy), .err_overrun(err_overrun)
    );

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick;
        load_we = 1'b0;
        mdl[a] = d;
    endtask

    // Start symbol plus 8 address chunks; returns just after the edge sampling the last chunk
    task automatic send_hdr(input logic [1:0] sym, input logic [15:0] a);
        tx_in = sym;
        tick;
        for (int i = 0; i < 8; i++) begin
            tx_in = a[2*i +: 2];
            tick;
        end
        tx_in = 2'b00;
    endtask

    task automatic write_frame(input logic [15:0] a, input logic [15:0] d,
                               input bit ld, input logic [15:0] ldv);
        send_hdr(2'b10, a);
        chk("wr_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            tx_in = d[2*i +: 2];
            load_we = ld && (i == 7); load_addr = a[AW-1:0]; load_data = ldv;
            tick;
        end
        tx_in = 2'b00; load_we = 1'b0;
        chk("wr_busy_end", busy, 0);
        if (WR_EN) mdl[a[AW-1:0]] = d;
        if (ld) mdl[a[AW-1:0]] = ldv;
    endtask

    // Response phase: checks delay, start symbol, error pulses; optional overrun injection / load
    task automatic collect(input int inj, input bit ld, input int ld_t,
                           input logic [AW-1:0] la, input logic [15:0] ldv,
                           output logic [15:0] w);
        w = '0;
        for (int t = 0; t < R + 9; t++) begin
            load_we = ld && (t == ld_t); load_addr = la; load_data = ldv;
            tx_in = (inj >= 0 && t == R + 1 + inj) ? 2'b01 : 2'b00;
            tick;
            if (load_we) mdl[la] = ldv;
            load_we = 1'b0; tx_in = 2'b00;
            if (t < R)       chk("wait_rx", rx_out, 0);
            else if (t == R) chk("start_sym", rx_out, 2'b01);
            else             w[2*(t-R-1) +: 2] = rx_out;
            chk("err_pulse", err_overrun, (inj >= 0 && t == R + 1 + inj) ? 1 : 0);
        end
        chk("rd_busy_end", busy, 0);
    endtask

    task automatic read_chk(input string nm, input logic [15:0] a, input int inj,
                            input bit ld, input int ld_t, input logic [AW-1:0] la,
                            input logic [15:0] ldv);
        logic [15:0] exp, w;
        exp = mdl[a[AW-1:0]];
        send_hdr(2'b01, a);
        chk("rd_busy", busy, 1);
        collect(inj, ld, ld_t, la, ldv, w);
        chk(nm, w, exp);
    endtask

    initial begin
        logic [15:0] w, ov;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_rx", rx_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_overrun, 0);
        @(negedge clk); rst_n = 1'b1; ena = 1'b1;
        tick;

        for (int a = 0; a < (1 << AW); a++) load(AW'(a), 16'($urandom));
        load(10'h005, 16'hBEEF);
        load(10'h010, 16'h5A5A);
        load(10'h3FF, 16'h7777);

        tbl[0] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF};
        tbl[1] = '{1'b0, 16'hFC05, 16'h0000, 16'hBEEF};
        tbl[2] = '{1'b1, 16'h0010, 16'h1234, 16'h0000};
        tbl[3] = '{1'b0, 16'h0010, 16'h0000, WR_EN ? 16'h1234 : 16'h5A5A};
        tbl[4] = '{1'b1, 16'h8010, 16'hCAFE, 16'h0000};
        tbl[5] = '{1'b0, 16'h0010, 16'h0000, WR_EN ? 16'hCAFE : 16'h5A5A};
        tbl[6] = '{1'b0, 16'hFFFF, 16'h0000, 16'h7777};

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].wr) begin
                write_frame(tbl[i].addr, tbl[i].data, 1'b0, 16'h0);
            end else begin
                send_hdr(2'b01, tbl[i].addr);
                collect(-1, 1'b0, 0, '0, '0, w);
                chk($sformatf("tbl%0d", i), w, tbl[i].exp);
            end
            tick;
        end

        // Overrun during RDATA leaves the response intact; 11 in IDLE pulses and stays idle
        read_chk("overrun_rd", 16'h0005, 3, 1'b0, 0, '0, '0);
        tx_in = 2'b11; tick; tx_in = 2'b00;
        chk("idle11_err", err_overrun, 1);
        chk("idle11_busy", busy, 0);
        tick;
        chk("idle11_err_clr", err_overrun, 0);

        // ena dropped at address chunk 4 aborts the frame
        tx_in = 2'b01; tick;
        for (int i = 0; i < 4; i++) begin tx_in = 2'b10; tick; end
        ena = 1'b0; tx_in = 2'b11; tick;
        chk("ena_busy", busy, 0);
        chk("ena_rx", rx_out, 0);
        ena = 1'b1; tx_in = 2'b00; tick;
        chk("ena_idle", busy, 0);
        read_chk("after_ena", 16'h0005, -1, 1'b0, 0, '0, '0);

        // Back-to-back reads with no idle gap
        read_chk("b2b_0", 16'h0010, -1, 1'b0, 0, '0, '0);
        read_chk("b2b_1", 16'h03FF, -1, 1'b0, 0, '0, '0);

        // Load on the read-issue edge returns old data; load during RDATA doesn't disturb it
        ov = mdl[10'h020];
        read_chk("rbw_old", 16'h0020, -1, 1'b1, 0, 10'h020, ~ov);
        read_chk("rbw_new", 16'h0020, -1, 1'b1, R + 3, 10'h020, 16'h1357);
        read_chk("late_load", 16'h0020, -1, 1'b0, 0, '0, '0);

        // Load beats a console write landing on the same edge
        write_frame(16'h0030, 16'hAAAA, 1'b1, 16'h4242);
        read_chk("load_prio", 16'h0030, -1, 1'b0, 0, '0, '0);

        // Async reset in the middle of a response
        send_hdr(2'b01, 16'h0005);
        for (int i = 0; i < R + 4; i++) tick;
        rst_n = 1'b0; #1;
        chk("midrst_rx", rx_out, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        tick;
        read_chk("after_rst", 16'h0005, -1, 1'b0, 0, '0, '0);

        for (int n = 0; n < 60; n++) begin
            int op;
            logic [15:0] a;
            op = $urandom_range(0, 3);
            a  = 16'($urandom);
            if (op == 0) begin
                write_frame(a, 16'($urandom), 1'b0, 16'h0);
            end else if (op == 1) begin
                load(AW'($urandom), 16'($urandom));
            end else begin
                read_chk("rand_rd", a,
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                         $urandom_range(0, 1) == 1, int'($urandom_range(0, R + 8)),
                         ($urandom_range(0, 1) == 1) ? a[AW-1:0] : AW'($urandom),
                         16'($urandom));
            end
            if ($urandom_range(0, 1) == 1) tick;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
